// File: rtl/pet_needs_engine.sv
// rtl/pet_needs_engine.sv - pet need decay, restore commands and life-state FSM
module pet_needs_engine #(
  parameter int STAT_MAX      = 10,
  parameter int HUNGER_PERIOD = 30,
  parameter int ENERGY_PERIOD = 45,
  parameter int JOY_PERIOD    = 20,
  parameter int LOW_THRESH    = 3,
  parameter int CMD_GAIN      = 3,
  parameter int DEATH_TICKS   = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        secondpassed,
  input  logic        cmd_feed,
  input  logic        cmd_sleep,
  input  logic        cmd_play,
  output logic        tick,
  output logic [3:0]  hunger,
  output logic [3:0]  energy,
  output logic [3:0]  joy,
  output logic [2:0]  low_flags,
  output logic [1:0]  life_state,
  output logic [15:0] seconds
);

  localparam int HW = $clog2(HUNGER_PERIOD + 1);
  localparam int EW = $clog2(ENERGY_PERIOD + 1);
  localparam int JW = $clog2(JOY_PERIOD + 1);
  localparam int SW = $clog2(DEATH_TICKS + 1);

  localparam logic [HW-1:0] H_LAST = HW'(HUNGER_PERIOD - 1);
  localparam logic [EW-1:0] E_LAST = EW'(ENERGY_PERIOD - 1);
  localparam logic [JW-1:0] J_LAST = JW'(JOY_PERIOD - 1);
  localparam logic [SW-1:0] S_LAST = SW'(DEATH_TICKS - 1);
  localparam logic [3:0]    MAX4   = 4'(STAT_MAX);
  localparam logic [4:0]    MAX5   = 5'(STAT_MAX);
  localparam logic [4:0]    GAIN5  = 5'(CMD_GAIN);
  localparam logic [3:0]    LT4    = 4'(LOW_THRESH);

  typedef enum logic [1:0] {
    ALIVE    = 2'b00,
    CRITICAL = 2'b01,
    DEAD     = 2'b10
  } life_e;

  life_e          state_q, state_d;
  logic           sp_q, tick_q;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [EW-1:0]  ecnt_q, ecnt_d;
  logic [JW-1:0]  jcnt_q, jcnt_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [3:0]     hunger_q, hunger_d, energy_q, energy_d, joy_q, joy_d;
  logic [15:0]    seconds_q, seconds_d;
  logic           live, tick_en, h_ev, e_ev, j_ev;
  logic           feed_en, sleep_en, play_en, any_zero;

  // Saturating decay first, then saturating restore, so both apply in one cycle.
  function automatic logic [3:0] upd(input logic [3:0] old, input logic [1:0] dec,
                                     input logic restore);
    logic [4:0] s;
    s = ({1'b0, old} > {3'b000, dec}) ? ({1'b0, old} - {3'b000, dec}) : 5'd0;
    if (restore) s = s + GAIN5;
    return (s > MAX5) ? MAX4 : s[3:0];
  endfunction

  assign live     = (state_q != DEAD);
  assign tick_en  = tick_q & live;
  assign feed_en  = cmd_feed & live;
  assign sleep_en = cmd_sleep & live;
  assign play_en  = cmd_play & live;

  assign h_ev = tick_en & (hcnt_q == H_LAST);
  assign e_ev = tick_en & (ecnt_q == E_LAST);
  assign j_ev = tick_en & (jcnt_q == J_LAST);

  always_comb begin
    hcnt_d    = hcnt_q;
    ecnt_d    = ecnt_q;
    jcnt_d    = jcnt_q;
    seconds_d = seconds_q;
    if (tick_en) begin
      hcnt_d    = h_ev ? '0 : hcnt_q + 1'b1;
      ecnt_d    = e_ev ? '0 : ecnt_q + 1'b1;
      jcnt_d    = j_ev ? '0 : jcnt_q + 1'b1;
      seconds_d = seconds_q + 16'd1;
    end
    hunger_d = upd(hunger_q, {1'b0, h_ev}, feed_en);
    energy_d = upd(energy_q, {1'b0, e_ev} + {1'b0, play_en}, sleep_en);
    joy_d    = upd(joy_q, {1'b0, j_ev}, play_en);
  end

  assign any_zero = (hunger_q == 4'd0) | (energy_q == 4'd0) | (joy_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ALIVE: begin
        starve_d = '0;
        if (any_zero) state_d = CRITICAL;
      end
      CRITICAL: begin
        if (!any_zero) begin
          state_d  = ALIVE;
          starve_d = '0;
        end else if (tick_en) begin
          starve_d = starve_q + 1'b1;
          if (starve_q == S_LAST) state_d = DEAD;
        end
      end
      DEAD:    state_d = DEAD;
      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q      <= 1'b0;
      tick_q    <= 1'b0;
      hcnt_q    <= '0;
      ecnt_q    <= '0;
      jcnt_q    <= '0;
      starve_q  <= '0;
      hunger_q  <= MAX4;
      energy_q  <= MAX4;
      joy_q     <= MAX4;
      seconds_q <= 16'd0;
      state_q   <= ALIVE;
    end else begin
      sp_q      <= secondpassed;
      tick_q    <= secondpassed ^ sp_q;
      hcnt_q    <= hcnt_d;
      ecnt_q    <= ecnt_d;
      jcnt_q    <= jcnt_d;
      starve_q  <= starve_d;
      hunger_q  <= hunger_d;
      energy_q  <= energy_d;
      joy_q     <= joy_d;
      seconds_q <= seconds_d;
      state_q   <= state_d;
    end
  end

  assign tick       = tick_q;
  assign hunger     = hunger_q;
  assign energy     = energy_q;
  assign joy        = joy_q;
  assign seconds    = seconds_q;
  assign life_state = state_q;
  assign low_flags  = {joy_q <= LT4, energy_q <= LT4, hunger_q <= LT4};

endmodule

// File: tb/tb_pet_needs_engine.sv
// tb/tb_pet_needs_engine.sv - directed vector bench for pet_needs_engine
module tb_pet_needs_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sp = 1'b0;
  logic        feed = 1'b0;
  logic        sleep = 1'b0;
  logic        play = 1'b0;
  logic        tick;
  logic [3:0]  hunger, energy, joy;
  logic [2:0]  low_flags;
  logic [1:0]  life_state;
  logic [15:0] seconds;

  int vectors = 0;
  int miscompares = 0;

  pet_needs_engine #(
    .STAT_MAX(10), .HUNGER_PERIOD(2), .ENERGY_PERIOD(3), .JOY_PERIOD(4),
    .LOW_THRESH(3), .CMD_GAIN(3), .DEATH_TICKS(4)
  ) dut (
    .clk(clk), .reset(reset), .secondpassed(sp),
    .cmd_feed(feed), .cmd_sleep(sleep), .cmd_play(play),
    .tick(tick), .hunger(hunger), .energy(energy), .joy(joy),
    .low_flags(low_flags), .life_state(life_state), .seconds(seconds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sp, feed, sleep, play, tick;
    logic [3:0]  h, e, j;
    logic [15:0] sec;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] h, input logic [3:0] e,
                             input logic [3:0] j, input logic [15:0] s, input logic [1:0] l);
    logic [2:0] lf;
    lf = {j <= 4'd3, e <= 4'd3, h <= 4'd3};
    chk({tag, ".hunger"}, 16'(hunger), 16'(h));
    chk({tag, ".energy"}, 16'(energy), 16'(e));
    chk({tag, ".joy"}, 16'(joy), 16'(j));
    chk({tag, ".seconds"}, seconds, s);
    chk({tag, ".life"}, 16'(life_state), 16'(l));
    chk({tag, ".low"}, 16'(low_flags), 16'(lf));
  endtask

  task automatic do_tick(input logic f, input logic s, input logic p);
    sp = ~sp;
    @(negedge clk);
    chk("tick_pulse", 16'(tick), 16'd1);
    feed = f; sleep = s; play = p;
    @(negedge clk);
    feed = 1'b0; sleep = 1'b0; play = 1'b0;
  endtask

  initial begin
    // sp feed sleep play | tick hunger energy joy seconds
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8,  4'd9,  4'd9,  16'd4};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8,  4'd9,  4'd9,  16'd5};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8,  4'd9,  4'd9,  16'd5};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 4'd8,  4'd9,  16'd6};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 4'd8,  4'd9,  16'd6};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 4'd8,  4'd9,  16'd7};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 4'd8,  4'd9,  16'd7};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9,  4'd8,  4'd8,  16'd8};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 4'd8,  4'd8,  16'd8};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10, 4'd10, 4'd10, 16'd8};

    #2 reset = 1'b1;
    #1;
    check_state("rst", 4'd10, 4'd10, 4'd10, 16'd0, 2'd0);
    chk("rst.tick", 16'(tick), 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      int cnt;
      cnt = 0;
      sp = ~sp;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (tick) cnt++;
        if (c == 1) chk("tick_latency", 16'(tick), 16'd1);
      end
      chk("tick_width", 16'(cnt), 16'd1);
    end
    check_state("four_ticks", 4'd8, 4'd9, 4'd9, 16'd4, 2'd0);

    for (int i = 0; i < 10; i++) begin
      sp = tbl[i].sp; feed = tbl[i].feed; sleep = tbl[i].sleep; play = tbl[i].play;
      @(negedge clk);
      chk("tbl.tick", 16'(tick), 16'(tbl[i].tick));
      check_state("tbl", tbl[i].h, tbl[i].e, tbl[i].j, tbl[i].sec, 2'd0);
    end
    feed = 1'b0; sleep = 1'b0; play = 1'b0;

    repeat (20) do_tick(1'b0, 1'b0, 1'b0);
    check_state("drain", 4'd0, 4'd3, 4'd5, 16'd28, 2'd0);
    @(negedge clk);
    check_state("enter_crit", 4'd0, 4'd3, 4'd5, 16'd28, 2'd1);
    repeat (2) do_tick(1'b0, 1'b0, 1'b0);
    check_state("floor0", 4'd0, 4'd2, 4'd5, 16'd30, 2'd1);
    do_tick(1'b0, 1'b0, 1'b0);
    check_state("crit3", 4'd0, 4'd2, 4'd5, 16'd31, 2'd1);
    feed = 1'b1;
    @(negedge clk);
    feed = 1'b0;
    check_state("feed_rec", 4'd3, 4'd2, 4'd5, 16'd31, 2'd1);
    @(negedge clk);
    check_state("alive_again", 4'd3, 4'd2, 4'd5, 16'd31, 2'd0);

    do_tick(1'b0, 1'b0, 1'b0);
    check_state("pre_play", 4'd2, 4'd2, 4'd4, 16'd32, 2'd0);
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    check_state("play_idle", 4'd2, 4'd1, 4'd7, 16'd32, 2'd0);
    do_tick(1'b0, 1'b0, 1'b1);
    check_state("play_decay", 4'd2, 4'd0, 4'd10, 16'd33, 2'd0);
    @(negedge clk);
    check_state("recrit", 4'd2, 4'd0, 4'd10, 16'd33, 2'd1);

    repeat (3) do_tick(1'b0, 1'b0, 1'b0);
    check_state("starve3", 4'd0, 4'd0, 4'd9, 16'd36, 2'd1);
    do_tick(1'b0, 1'b0, 1'b0);
    check_state("dead", 4'd0, 4'd0, 4'd9, 16'd37, 2'd2);
    feed = 1'b1; sleep = 1'b1; play = 1'b1;
    @(negedge clk);
    feed = 1'b0; sleep = 1'b0; play = 1'b0;
    check_state("dead_cmd", 4'd0, 4'd0, 4'd9, 16'd37, 2'd2);
    repeat (2) do_tick(1'b0, 1'b0, 1'b0);
    check_state("dead_frozen", 4'd0, 4'd0, 4'd9, 16'd37, 2'd2);

    reset = 1'b1;
    #1;
    check_state("rst_mid", 4'd10, 4'd10, 4'd10, 16'd0, 2'd0);
    chk("rst_mid.tick", 16'(tick), 16'd0);
    sp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sp = 1'b1;
    @(negedge clk);
    chk("post_rst.tick", 16'(tick), 16'd1);
    @(negedge clk);
    chk("post_rst.tick_off", 16'(tick), 16'd0);
    check_state("post_rst", 4'd10, 4'd10, 4'd10, 16'd1, 2'd0);

    for (int b = 0; b < 6; b++) begin
      sp = ~sp;
      @(negedge clk);
      chk("burst.tick", 16'(tick), 16'd1);
    end
    @(negedge clk);
    chk("burst.tick_off", 16'(tick), 16'd0);
    check_state("burst", 4'd7, 4'd8, 4'd9, 16'd7, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pet_needs_engine.md
# pet_needs_engine

Consumer of the toggling time base emitted by the game's time-control block. It turns each transition of `secondpassed` into a one-cycle tick and uses those ticks to decay the pet's three needs: hunger, energy and joy. It applies restore commands from the button/menu logic and runs the alive/critical/dead life-state machine that the display and sound blocks read.

## Interface
Parameters:
- STAT_MAX, 10: full value of each need (4-bit range, ≤15).
- HUNGER_PERIOD, 30: ticks per hunger decrement (≥1).
- ENERGY_PERIOD, 45: ticks per energy decrement (≥1).
- JOY_PERIOD, 20: ticks per joy decrement (≥1).
- LOW_THRESH, 3: a need at or below this value raises its low flag.
- CMD_GAIN, 3: amount restored by one command.
- DEATH_TICKS, 60: consecutive ticks in CRITICAL before DEAD (≥1).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high; clock clk.
- secondpassed  in  1  time-base level; every transition (rise or fall) is one elapsed period. Synchronous to clk.
- cmd_feed  in  1  one-cycle pulse; restores hunger.
- cmd_sleep  in  1  one-cycle pulse; restores energy.
- cmd_play  in  1  one-cycle pulse; restores joy and costs 1 energy.
- tick  out  1  one-cycle pulse per detected transition.
- hunger, energy, joy  out  4 each  current need values.
- low_flags  out  3  {joy, energy, hunger} ≤ LOW_THRESH.
- life_state  out  2  00 ALIVE, 01 CRITICAL, 10 DEAD (11 unused).
- seconds  out  16  tick count since reset.

## Operation
- Edge detect: sp_d registers secondpassed and resets to 0. tick is registered: tick <= secondpassed ^ sp_d.
- A secondpassed that is already 1 at reset release produces one tick. This is intended.
- seconds: +1 on each tick; wraps 65535→0; frozen in DEAD.
- Dividers: each need has its own counter, 0..PERIOD-1, advanced on tick.
  - A tick arriving when the counter = PERIOD-1 wraps it to 0 and raises that need's decay event.
  - PERIOD=1 means a decay on every tick.
- Need update, all in one cycle:
  - dec = decay event + (cmd_play for energy only).
  - new = min(max(old − dec, 0) + (command ? CMD_GAIN : 0), STAT_MAX).
  - Decay is saturating at 0. Restore is saturating at STAT_MAX.
  - Commands arriving on the same cycle as decay, and multiple commands in one cycle, are all honoured by this formula.
- Commands are ignored in DEAD. Decay, dividers and seconds all stop in DEAD.
- low_flags are combinational from the need registers.
- Life FSM, evaluated on registered need values:
  - ALIVE → CRITICAL when any need = 0.
  - CRITICAL → ALIVE when all needs ≠ 0; starve counter cleared.
  - In CRITICAL, the starve counter increments per tick. When a tick brings it to DEATH_TICKS → DEAD.
  - If a need recovers on the same cycle as the fatal tick, recovery wins (→ ALIVE).
  - DEAD is terminal until reset.
- Reset, asynchronous, at any time including mid-decay:
  - hunger = energy = joy = STAT_MAX.
  - dividers, starve counter, seconds = 0.
  - tick = 0, sp_d = 0, life_state = ALIVE.
  - low_flags = 000 (given LOW_THRESH < STAT_MAX).

## Timing
- secondpassed edge at cycle N → tick high at N+1, for exactly 1 cycle.
- Decay driven by that tick → need register updated at N+2. seconds updates at N+2.
- Command pulse at cycle M → need updated at M+1. low_flags follows in the same cycle as the need.
- Need reaching 0 at cycle K → life_state = CRITICAL at K+1.
- The fatal tick is seen at cycle T → life_state = DEAD at T+1.
- Throughput: one tick per clk is supported. Two transitions on consecutive cycles give two ticks.

## Test plan
The bench uses HUNGER_PERIOD=2, ENERGY_PERIOD=3, JOY_PERIOD=4, STAT_MAX=10, CMD_GAIN=3, LOW_THRESH=3, DEATH_TICKS=4.
- Reset with secondpassed=0, then 4 toggles spaced 10 cycles apart.
  - Required: 4 one-cycle ticks, each 1 cycle after its edge.
  - Required: seconds=4, hunger=8, energy=9, joy=9.
- cmd_feed at hunger=9 → hunger=10 (saturated). Then 20 ticks → hunger=0. Further ticks keep hunger=0, no underflow.
- cmd_play with energy=1 on the same cycle as an energy decay event → energy=0, joy +3. life_state=CRITICAL the following cycle.
- Enter CRITICAL, deliver 3 ticks, then cmd_feed.
  - Required: ALIVE, starve counter cleared.
  - Re-enter CRITICAL and deliver 4 ticks → DEAD. Commands and ticks then change nothing; seconds stays frozen.
- Assert reset mid-run (DEAD, needs 0) → all outputs return to their reset values immediately. The first toggle after release ticks normally.
- Toggle secondpassed every cycle for 6 cycles → 6 consecutive tick cycles and seconds +6.
